pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Source end of the 6-bit pipeline stall vector read by every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb).
//  Merges per-stage stall requests into stall[5:0].
//  Sequences multi-cycle EX operations such as madd/msub/div, holding PC..EX for a programmed number of cycles.
//  Counts total stalled cycles for performance debug.
// PARAMETERS
//  CNT_W  6  width of ex_mc_cycles and internal down-counter (max 63 stall cycles)
// PORTS
//  clk               in   1      system clock, rising edge
//  rst               in   1      asynchronous reset, active-low (asserted when rst==0)
//  stallreq_from_id  in   1      ID hazard (load-use) request, combinational
//  stallreq_from_ex  in   1      generic EX request, combinational
//  stallreq_from_mem in   1      MEM wait request, combinational
//  ex_mc_start       in   1      EX presents multi-cycle op this cycle
//  ex_mc_cycles      in   CNT_W  stall cycles N requested with ex_mc_start
//  ex_mc_cancel      in   1      flush: abort multi-cycle op
//  stall             out  6      [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1=Stop
//  ex_mc_busy        out  1      multi-cycle op in progress (state BUSY)
//  ex_mc_done        out  1      result valid, EX may advance (state DONE)
//  stall_cycles      out  32     saturating count of cycles with stall[0]==1
// BEHAVIOUR
//  Reset (rst==0, async): state=IDLE, cnt=0, stall_cycles=0; stall forced 6'b000000, busy=0, done=0.
//  Stall vector (combinational, highest match wins):
//   stallreq_from_mem             -> 6'b011111
//   stallreq_from_ex | mc_hold    -> 6'b001111
//   stallreq_from_id              -> 6'b000111
//   none                          -> 6'b000000
//  Only contiguous low-order patterns are legal; 6'b100000 etc. never produced.
//  mc_hold = (state==BUSY) | (state==IDLE & ex_mc_start & ex_mc_cycles!=0 & !ex_mc_cancel).
//  FSM (registered, state/cnt update on posedge clk):
//   IDLE: start & N!=0 & !cancel -> N==1 ? DONE : BUSY with cnt=N-1. N==0: no-op, stay IDLE, no done.
//   BUSY: mem stall -> hold (cnt frozen). Otherwise cnt-=1; cnt==1 -> DONE.
//   DONE: done=1, mc_hold=0. Stays while stall[3]==1 (mem or id/ex stall). Exits to IDLE when stall[3]==0.
//        ex_mc_start is ignored in DONE (same instruction).
//   Any state: ex_mc_cancel -> IDLE, cnt=0 next edge. Cancel beats start in same cycle.
//        mc_hold is dropped in the cancel cycle.
//  Timing: start with N at cycle T, no other requests -> stall[3:0] high T..T+N-1, done high at T+N, IDLE at T+N+1.
//  cnt never underflows; arithmetic is unsigned CNT_W bits.
//  stall_cycles += 1 on each edge where stall[0]==1. Saturates at 32'hFFFF_FFFF (no wrap).
//  busy = (state==BUSY); done = (state==DONE); both are pure state decodes.
// TESTING
//  1. Idle, id req 1 cycle -> stall=6'b000111 that cycle, 6'b000000 after; stall_cycles=1.
//  2. start N=3 at T -> stall=6'b001111 T,T+1,T+2; busy T+1,T+2; done T+3 only; stall_cycles=3.
//  3. start N=1 -> stall 1 cycle, state goes straight to DONE, busy never high. Also start N=0 -> no stall, no done.
//  4. start N=4, mem req at T+1..T+2 -> stall=6'b011111 there, cnt frozen; done at T+6.
//     Also N=2 with mem held during DONE -> done stays high until mem drops.
//  5. start N=5, cancel at T+2 -> stall=6'b000000 at T+2 (no other req), IDLE T+3, no done.
//     Also start+cancel same cycle -> no stall.
//  6. Reset asserted mid-BUSY (async, between edges) -> stall=0, busy=0 immediately; stall_cycles=0.
//     Also force stall_cycles near max -> saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges per-stage stall requests into the pipeline stall vector,
// sequences multi-cycle EX ops and counts stalled cycles.
module pipe_stall_ctrl #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             ex_mc_cancel,
  output logic [5:0]       stall,
  output logic             ex_mc_busy,
  output logic             ex_mc_done,
  output logic [31:0]      stall_cycles
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic mc_start_ok;
  logic mc_hold;
  assign mc_start_ok = state == IDLE && ex_mc_start && ex_mc_cycles != '0 && !ex_mc_cancel;
  assign mc_hold = !ex_mc_cancel && (state == BUSY || mc_start_ok);
  // Reset overrides the combinational request path so no stage is held while in reset.
  always_comb
    stall = !rst              ? 6'b000000 :
            stallreq_from_mem ? 6'b011111 :
            (stallreq_from_ex || mc_hold) ? 6'b001111 :
            stallreq_from_id  ? 6'b000111 : 6'b000000;
  assign ex_mc_busy = state == BUSY;
  assign ex_mc_done = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (ex_mc_cancel) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (mc_start_ok) begin
        state <= ex_mc_cycles == CNT_W'(1) ? DONE : BUSY;
        cnt   <= ex_mc_cycles - CNT_W'(1);
      end
    end else if (state == BUSY) begin
      if (!stallreq_from_mem) begin
        cnt   <= cnt - CNT_W'(1);
        state <= cnt == CNT_W'(1) ? DONE : BUSY;
      end
    end else if (state == DONE) begin
      state <= stall[3] ? DONE : IDLE;
    end else begin
      state <= IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cycles <= '0;
    else if (stall[0] && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: scoreboard bench, expectations queued at drive time and checked mid-cycle.
module tb_pipe_stall_ctrl;
  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;
  localparam logic [5:0] SM = 6'b011111;
  typedef struct {
    logic [5:0]  s;
    logic        b;
    logic        d;
    logic [31:0] c;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic id_req, ex_req, mem_req, mc_start, mc_cancel;
  logic [5:0] mc_cycles;
  logic [5:0] stall;
  logic busy, done;
  logic [31:0] stall_cycles;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sc_model = 0;
  exp_t q[$];
  pipe_stall_ctrl #(.CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_id(id_req), .stallreq_from_ex(ex_req), .stallreq_from_mem(mem_req),
    .ex_mc_start(mc_start), .ex_mc_cycles(mc_cycles), .ex_mc_cancel(mc_cancel),
    .stall(stall), .ex_mc_busy(busy), .ex_mc_done(done), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic id, input logic ex, input logic mem, input logic st,
                     input logic [5:0] n, input logic cn,
                     input logic [5:0] es, input logic eb, input logic ed);
    exp_t e;
    @(posedge clk);
    #1;
    id_req = id; ex_req = ex; mem_req = mem; mc_start = st; mc_cycles = n; mc_cancel = cn;
    e.s = es; e.b = eb; e.d = ed; e.c = sc_model;
    q.push_back(e);
    if (es[0] && sc_model != 32'hFFFF_FFFF) sc_model = sc_model + 1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", {26'd0, stall}, {26'd0, e.s});
      chk("busy", {31'd0, busy}, {31'd0, e.b});
      chk("done", {31'd0, done}, {31'd0, e.d});
      chk("stall_cycles", stall_cycles, e.c);
    end
  end
  initial begin
    rst = 1'b0;
    {id_req, ex_req, mem_req, mc_start, mc_cancel} = '0;
    mc_cycles = '0;
    id_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_stall", {26'd0, stall}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sc", stall_cycles, 32'd0);
    id_req = 1'b0;
    rst = 1'b1;
    // load-use stall for one cycle
    cyc(1,0,0, 0,0,0, SI,0,0);
    cyc(0,0,0, 0,0,0, S0,0,0);
    cyc(0,1,0, 0,0,0, SE,0,0);
    // N=3 multi-cycle op
    cyc(0,0,0, 1,3,0, SE,0,0);
    cyc(0,0,0, 0,0,0, SE,1,0);
    cyc(0,0,0, 0,0,0, SE,1,0);
    cyc(0,0,0, 0,0,0, S0,0,1);
    cyc(0,0,0, 0,0,0, S0,0,0);
    // N=1 goes straight to DONE, N=0 is a no-op
    cyc(0,0,0, 1,1,0, SE,0,0);
    cyc(0,0,0, 0,0,0, S0,0,1);
    cyc(0,0,0, 0,0,0, S0,0,0);
    cyc(0,0,0, 1,0,0, S0,0,0);
    cyc(0,0,0, 0,0,0, S0,0,0);
    // N=4 with MEM stall freezing the counter
    cyc(0,0,0, 1,4,0, SE,0,0);
    cyc(0,0,1, 0,0,0, SM,1,0);
    cyc(0,0,1, 0,0,0, SM,1,0);
    cyc(0,0,0, 0,0,0, SE,1,0);
    cyc(0,0,0, 0,0,0, SE,1,0);
    cyc(0,0,0, 0,0,0, SE,1,0);
    cyc(0,0,0, 0,0,0, S0,0,1);
    cyc(0,0,0, 0,0,0, S0,0,0);
    // N=2 with MEM held during DONE, start ignored in DONE
    cyc(0,0,0, 1,2,0, SE,0,0);
    cyc(0,0,0, 0,0,0, SE,1,0);
    cyc(0,0,1, 1,3,0, SM,0,1);
    cyc(0,0,1, 0,0,0, SM,0,1);
    cyc(0,0,0, 1,3,0, S0,0,1);
    cyc(0,0,0, 0,0,0, S0,0,0);
    // N=5 cancelled mid-op, then start+cancel together
    cyc(0,0,0, 1,5,0, SE,0,0);
    cyc(0,0,0, 0,0,0, SE,1,0);
    cyc(0,0,0, 0,0,1, S0,1,0);
    cyc(0,0,0, 0,0,0, S0,0,0);
    cyc(0,0,0, 0,0,0, S0,0,0);
    cyc(0,0,0, 1,3,1, S0,0,0);
    cyc(0,0,0, 0,0,0, S0,0,0);
    // async reset in the middle of BUSY
    cyc(0,0,0, 1,5,0, SE,0,0);
    cyc(1,0,0, 0,0,0, SE,1,0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_stall", {26'd0, stall}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_sc", stall_cycles, 32'd0);
    @(negedge clk);
    #1;
    id_req = 1'b0;
    rst = 1'b1;
    sc_model = 0;
    cyc(0,0,0, 0,0,0, S0,0,0);
    @(negedge clk);
    #1;
    dut.stall_cycles = 32'hFFFF_FFFD;
    sc_model = 32'hFFFF_FFFD;
    // saturation of the stall counter
    cyc(1,0,0, 0,0,0, SI,0,0);
    cyc(1,0,0, 0,0,0, SI,0,0);
    cyc(1,0,0, 0,0,0, SI,0,0);
    cyc(1,0,0, 0,0,0, SI,0,0);
    cyc(0,0,0, 0,0,0, S0,0,0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
